// File: rtl/alu_simd_result_unpacker_if.sv
// alu_simd_result_unpacker_if: packed-result input and unpacked beat stream of the result unpacker
interface alu_simd_result_unpacker_if #(parameter int LEVEL_W = 5);
   logic in_valid;
   logic in_ready;
   logic USE_SIMD;
   logic [44:0] S;
   logic [3:0] carry_out;
   logic out_valid;
   logic out_ready;
   logic [46:0] out_data;
   logic out_lane;
   logic out_last;
   logic [LEVEL_W-1:0] level;
   modport slave(
      input in_valid, USE_SIMD, S, carry_out, out_ready,
      output in_ready, out_valid, out_data, out_lane, out_last, level
   );
   modport master(
      output in_valid, USE_SIMD, S, carry_out, out_ready,
      input in_ready, out_valid, out_data, out_lane, out_last, level
   );
endinterface

// File: rtl/alu_simd_result_unpacker.sv
// alu_simd_result_unpacker: FIFO of packed ALU results serialized as one beat per wide result or per SIMD lane
module alu_simd_result_unpacker #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEVEL_W = 5
) (
   input logic clk,
   input logic reset,
   alu_simd_result_unpacker_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, HEAD0, HEAD1} state_t;
   state_t st;
   logic [49:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [LEVEL_W-1:0] lvl, lvl_n;
   logic [49:0] head;
   logic push, pop, hs, mode;
   assign bus.in_ready = !reset && (lvl < LEVEL_W'(FIFO_DEPTH));
   assign bus.level = lvl;
   assign push = bus.in_valid && bus.in_ready;
   assign head = mem[rp];
   assign mode = head[49];
   assign hs = bus.out_valid && bus.out_ready;
   assign pop = hs && bus.out_last;
   assign lvl_n = lvl + LEVEL_W'(push) - LEVEL_W'(pop);
   // head[48:47] is the high-slice carry pair, head[46:45] the low-slice pair
   always_comb begin
      bus.out_valid = st != IDLE;
      bus.out_lane = st == HEAD1;
      bus.out_last = (st == HEAD1) || (st == HEAD0 && !mode);
      bus.out_data = st == HEAD1 ? {27'b0, head[48:47], head[44:27]} :
                     st == HEAD0 ? (mode ? {18'b0, head[46:45], head[26:0]} : {head[48:47], head[44:0]}) : '0;
   end
   always_ff @(posedge clk) if (push) mem[wp] <= {bus.USE_SIMD, bus.carry_out, bus.S};
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= IDLE;
         wp <= '0;
         rp <= '0;
         lvl <= '0;
      end else begin
         lvl <= lvl_n;
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         if (hs) st <= bus.out_last ? (lvl_n != '0 ? HEAD0 : IDLE) : HEAD1;
         else if (st == IDLE && push) st <= HEAD0;
      end
   end
endmodule

// File: tb/tb_alu_simd_result_unpacker.sv
// tb_alu_simd_result_unpacker: directed self-checking bench for the SIMD result unpacker
module tb_alu_simd_result_unpacker;
   logic clk = 0;
   logic reset = 1;
   int checks = 0;
   int fails = 0;
   logic [46:0] eq_data[$];
   logic eq_lane[$];
   logic eq_last[$];
   alu_simd_result_unpacker_if #(.LEVEL_W(5)) bus();
   alu_simd_result_unpacker #(.FIFO_DEPTH(4), .LEVEL_W(5)) dut(.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [46:0] act, input logic [46:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic test_reset();
      reset = 1;
      bus.in_valid = 0;
      bus.USE_SIMD = 0;
      bus.S = '0;
      bus.carry_out = '0;
      bus.out_ready = 0;
      step();
      step();
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
      checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (bus.out_data !== 47'd0 || bus.out_lane !== 1'b0 || bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_outputs: got %h/%b/%b expected 0/0/0", bus.out_data, bus.out_lane, bus.out_last); end
      reset = 0;
      step();
      checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_wide();
      bus.out_ready = 1;
      bus.in_valid = 1;
      bus.USE_SIMD = 0;
      bus.S = 45'h1_2345_6789_AB;
      bus.carry_out = 4'b1000;
      step();
      bus.in_valid = 0;
      checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL wide_valid: got %b expected 1", bus.out_valid); end
      checks++; if (bus.out_data !== {2'b10, 45'h1_2345_6789_AB}) begin fails++; $display("FAIL wide_data: got %h expected %h", bus.out_data, {2'b10, 45'h1_2345_6789_AB}); end
      checks++; if (bus.out_lane !== 1'b0 || bus.out_last !== 1'b1) begin fails++; $display("FAIL wide_lane_last: got %b%b expected 01", bus.out_lane, bus.out_last); end
      checks++; if (bus.level !== 5'd1) begin fails++; $display("FAIL wide_level: got %0d expected 1", bus.level); end
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin fails++; $display("FAIL wide_drained: got valid %b level %0d expected 0 0", bus.out_valid, bus.level); end
   endtask

   task automatic test_simd();
      bus.out_ready = 1;
      bus.in_valid = 1;
      bus.USE_SIMD = 1;
      bus.S = {18'h3_0001, 27'h7FF_FFFF};
      bus.carry_out = 4'b0110;
      step();
      bus.in_valid = 0;
      bus.USE_SIMD = 0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== {18'b0, 2'b10, 27'h7FF_FFFF}) begin fails++; $display("FAIL simd_beat0: got %b %h expected 1 %h", bus.out_valid, bus.out_data, {18'b0, 2'b10, 27'h7FF_FFFF}); end
      checks++; if (bus.out_lane !== 1'b0 || bus.out_last !== 1'b0) begin fails++; $display("FAIL simd_beat0_lane_last: got %b%b expected 00", bus.out_lane, bus.out_last); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== {27'b0, 2'b01, 18'h3_0001}) begin fails++; $display("FAIL simd_beat1: got %b %h expected 1 %h", bus.out_valid, bus.out_data, {27'b0, 2'b01, 18'h3_0001}); end
      checks++; if (bus.out_lane !== 1'b1 || bus.out_last !== 1'b1) begin fails++; $display("FAIL simd_beat1_lane_last: got %b%b expected 11", bus.out_lane, bus.out_last); end
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin fails++; $display("FAIL simd_drained: got valid %b level %0d expected 0 0", bus.out_valid, bus.level); end
   endtask

   task automatic test_fill();
      bus.out_ready = 0;
      bus.USE_SIMD = 0;
      bus.carry_out = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1;
         bus.S = 45'(100 + i);
         checks++; if (bus.in_ready !== (i < 4)) begin fails++; $display("FAIL fill_in_ready_%0d: got %b expected %b", i, bus.in_ready, i < 4); end
         step();
      end
      checks++; if (bus.level !== 5'd4 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_full: got level %0d ready %b expected 4 0", bus.level, bus.in_ready); end
      bus.S = 45'd999;
      bus.out_ready = 1;
      checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_no_bypass: got %b expected 0", bus.in_ready); end
      chk("fill_head0", bus.out_data, {2'b00, 45'd100});
      step();
      bus.in_valid = 0;
      bus.out_ready = 0;
      checks++; if (bus.in_ready !== 1'b1 || bus.level !== 5'd3) begin fails++; $display("FAIL fill_after_pop: got ready %b level %0d expected 1 3", bus.in_ready, bus.level); end
      bus.out_ready = 1;
      for (int i = 1; i < 4; i++) begin
         chk($sformatf("fill_drain_%0d", i), bus.out_data, {2'b00, 45'(100 + i)});
         step();
      end
      checks++; if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin fails++; $display("FAIL fill_fifth_rejected: got valid %b level %0d expected 0 0", bus.out_valid, bus.level); end
   endtask

   task automatic test_stall();
      bus.out_ready = 1;
      bus.in_valid = 1;
      bus.USE_SIMD = 1;
      bus.S = {18'h2_AAAA, 27'h123_4567};
      bus.carry_out = 4'b1101;
      step();
      bus.in_valid = 0;
      chk("stall_beat0", bus.out_data, {18'b0, 2'b01, 27'h123_4567});
      step();
      bus.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_lane !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== {27'b0, 2'b11, 18'h2_AAAA}) begin
            fails++;
            $display("FAIL stall_hold_%0d: got %b%b%b %h expected 111 %h", i, bus.out_valid, bus.out_lane, bus.out_last, bus.out_data, {27'b0, 2'b11, 18'h2_AAAA});
         end
         step();
      end
      bus.out_ready = 1;
      chk("stall_release", bus.out_data, {27'b0, 2'b11, 18'h2_AAAA});
      step();
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stall_no_dup: got valid %b expected 0", bus.out_valid); end
   endtask

   task automatic test_mixed();
      logic [44:0] s;
      logic [3:0] c;
      int pushed = 0;
      int beats = 0;
      int cyc = 0;
      for (int i = 0; i < 10; i++) begin
         s = {18'(i * 3 + 1), 27'(i * 1000 + 7)};
         c = 4'(i + 5);
         if (i % 2 == 0) begin
            eq_data.push_back({c[3:2], s});
            eq_lane.push_back(0);
            eq_last.push_back(1);
         end else begin
            eq_data.push_back({18'b0, c[1:0], s[26:0]});
            eq_lane.push_back(0);
            eq_last.push_back(0);
            eq_data.push_back({27'b0, c[3:2], s[44:27]});
            eq_lane.push_back(1);
            eq_last.push_back(1);
         end
      end
      while (beats < 15 && cyc < 400) begin
         bus.in_valid = pushed < 10;
         bus.USE_SIMD = pushed % 2;
         bus.S = {18'(pushed * 3 + 1), 27'(pushed * 1000 + 7)};
         bus.carry_out = 4'(pushed + 5);
         bus.out_ready = $urandom_range(0, 2) == 0;
         if (bus.level > 5'd4) begin
            checks++;
            fails++;
            $display("FAIL mixed_level: got %0d expected <= 4", bus.level);
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (bus.out_data !== eq_data[0] || bus.out_lane !== eq_lane[0] || bus.out_last !== eq_last[0]) begin
               fails++;
               $display("FAIL mixed_beat_%0d: got %h/%b/%b expected %h/%b/%b", beats, bus.out_data, bus.out_lane, bus.out_last, eq_data[0], eq_lane[0], eq_last[0]);
            end
            void'(eq_data.pop_front());
            void'(eq_lane.pop_front());
            void'(eq_last.pop_front());
            beats++;
         end
         if (bus.in_valid && bus.in_ready) pushed++;
         step();
         cyc++;
      end
      bus.in_valid = 0;
      bus.out_ready = 0;
      checks++; if (beats != 15) begin fails++; $display("FAIL mixed_beat_count: got %0d expected 15", beats); end
      checks++; if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin fails++; $display("FAIL mixed_drained: got valid %b level %0d expected 0 0", bus.out_valid, bus.level); end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 0;
      bus.USE_SIMD = 1;
      bus.carry_out = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1;
         bus.S = 45'(i + 1);
         step();
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      step();
      bus.out_ready = 0;
      checks++; if (bus.out_lane !== 1'b1 || bus.level !== 5'd3) begin fails++; $display("FAIL mid_head1: got lane %b level %0d expected 1 3", bus.out_lane, bus.level); end
      reset = 1;
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin fails++; $display("FAIL mid_reset: got valid %b level %0d expected 0 0", bus.out_valid, bus.level); end
      reset = 0;
      bus.out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale_%0d: got valid %b expected 0", i, bus.out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_wide();
      test_simd();
      test_fill();
      test_stall();
      test_mixed();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
